button_debounce: RTL and testbench

- Front-end stage for the LED blinker. Synchronises and debounces one raw push-button (Tang Nano 20K S1/S2) on the 27 MHz board clock.
- Produces a clean level, single-cycle press/release/long-press pulses, and a 2-bit Mode register.
- The blinker consumes Mode to select its half-period pair. Short presses step Mode; a long press returns it to 0.

---
 rtl/button_debounce.sv | 145 ++++++++++++++
 tb/tb_button_debounce.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button front end: two-flop synchroniser, debounce FSM, press/release/long-press
// pulses and a 2-bit short-press Mode counter for the LED blinker.
module button_debounce #(
  parameter int unsigned CLOCK_FREQUENCY   = 27000000,
  parameter int unsigned DEBOUNCE_MS       = 20,
  parameter int unsigned LONG_PRESS_MS     = 1000,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Button_In,
  output logic       Button_Level,
  output logic       Press_Pulse,
  output logic       Release_Pulse,
  output logic       Long_Press_Pulse,
  output logic [1:0] Mode
);

  localparam int unsigned CyclesPerMs   = CLOCK_FREQUENCY / 1000;
  localparam logic [24:0] DEBOUNCE_COUNT = 25'(CyclesPerMs * DEBOUNCE_MS - 1);
  localparam logic [24:0] LONG_COUNT     = 25'(CyclesPerMs * LONG_PRESS_MS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e      state_q, state_d;
  logic        sync0_q, sync1_q;
  logic [24:0] db_cnt_q, db_cnt_d;
  logic [24:0] hold_cnt_q, hold_cnt_d;
  logic        long_fired_q, long_fired_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic [1:0]  mode_q, mode_d;
  logic        raw;

  // Normalise polarity so raw is 1 while the button is pressed.
  assign raw = sync1_q ^ BUTTON_ACTIVE_LOW;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync0_q      <= BUTTON_ACTIVE_LOW;
      sync1_q      <= BUTTON_ACTIVE_LOW;
      state_q      <= StIdle;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      mode_q       <= 2'd0;
    end else begin
      sync0_q      <= Button_In;
      sync1_q      <= sync0_q;
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
      mode_q       <= mode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    long_fired_d = long_fired_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;
    mode_d       = mode_q;
    unique case (state_q)
      StIdle: begin
        if (raw) begin
          state_d  = StPressWait;
          db_cnt_d = '0;
        end
      end
      StPressWait: begin
        if (!raw) begin
          state_d = StIdle;
        end else if (db_cnt_q == DEBOUNCE_COUNT) begin
          state_d      = StPressed;
          press_d      = 1'b1;
          level_d      = 1'b1;
          hold_cnt_d   = '0;
          long_fired_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 25'd1;
        end
      end
      StPressed: begin
        if (!raw) begin
          state_d  = StReleaseWait;
          db_cnt_d = '0;
        end else begin
          if (hold_cnt_q == LONG_COUNT && !long_fired_q) begin
            long_d       = 1'b1;
            long_fired_d = 1'b1;
            mode_d       = 2'd0;
          end
          // Saturate so a very long hold cannot wrap and re-arm the long press.
          if (hold_cnt_q != LONG_COUNT) begin
            hold_cnt_d = hold_cnt_q + 25'd1;
          end
        end
      end
      StReleaseWait: begin
        if (raw) begin
          state_d = StPressed;
        end else if (db_cnt_q == DEBOUNCE_COUNT) begin
          state_d   = StIdle;
          release_d = 1'b1;
          level_d   = 1'b0;
          if (!long_fired_q) begin
            mode_d = mode_q + 2'd1;
          end
        end else begin
          db_cnt_d = db_cnt_q + 25'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Button_Level     = level_q;
    Press_Pulse      = press_q;
    Release_Pulse    = release_q;
    Long_Press_Pulse = long_q;
    Mode             = mode_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random button runs, every cycle checked
// against a run-length model of the debounce and long-press rules.
module tb_button_debounce;

  localparam int D = 3;
  localparam int L = 9;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Button_In;
  logic       Button_Level;
  logic       Press_Pulse;
  logic       Release_Pulse;
  logic       Long_Press_Pulse;
  logic [1:0] Mode;

  button_debounce #(
    .CLOCK_FREQUENCY  (1000),
    .DEBOUNCE_MS      (4),
    .LONG_PRESS_MS    (10),
    .BUTTON_ACTIVE_LOW(1'b0)
  ) u_dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Button_In       (Button_In),
    .Button_Level    (Button_Level),
    .Press_Pulse     (Press_Pulse),
    .Release_Pulse   (Release_Pulse),
    .Long_Press_Pulse(Long_Press_Pulse),
    .Mode            (Mode)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Model: the pin reaches the decision logic two edges late; a level change is accepted
  // once D+2 consecutive samples disagree with the current level.
  bit m_s0, m_s1, m_prev, m_level, m_fired;
  int m_run, m_hold, m_mode;
  bit e_press, e_rel, e_long;

  int cyc = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int press_cyc = -1, rel_cyc = -1, long_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit pin);
    bit raw;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_long  = 1'b0;
    if (rst) begin
      m_s0 = 0; m_s1 = 0; m_prev = 0; m_level = 0; m_fired = 0;
      m_run = 0; m_hold = 0; m_mode = 0;
      return;
    end
    raw = m_s1;
    // Hold time counts edges spent pressed with the button still down.
    if (m_level && raw && m_prev) begin
      m_hold++;
      if (m_hold == L + 1 && !m_fired) begin
        e_long  = 1'b1;
        m_fired = 1'b1;
        m_mode  = 0;
      end
    end
    if (raw != m_level) m_run++;
    else m_run = 0;
    if (m_run == D + 2) begin
      m_run = 0;
      if (!m_level) begin
        m_level = 1'b1;
        e_press = 1'b1;
        m_hold  = 0;
        m_fired = 1'b0;
      end else begin
        m_level = 1'b0;
        e_rel   = 1'b1;
        if (!m_fired) m_mode = (m_mode + 1) % 4;
      end
    end
    m_prev = raw;
    m_s1   = m_s0;
    m_s0   = pin;
  endtask

  task automatic step(input bit rst, input bit pin);
    Reset     = rst;
    Button_In = pin;
    @(posedge Clock);
    cyc++;
    model_edge(rst, pin);
    #1;
    check("level", 32'(Button_Level), 32'(m_level));
    check("press", 32'(Press_Pulse), 32'(e_press));
    check("release", 32'(Release_Pulse), 32'(e_rel));
    check("long", 32'(Long_Press_Pulse), 32'(e_long));
    check("mode", 32'(Mode), 32'(m_mode));
    check("exclusive", 32'((32'(Press_Pulse) + 32'(Release_Pulse) + 32'(Long_Press_Pulse)) <= 1),
          32'd1);
    if (Press_Pulse === 1'b1) begin n_press++; press_cyc = cyc; end
    if (Release_Pulse === 1'b1) begin n_rel++; rel_cyc = cyc; end
    if (Long_Press_Pulse === 1'b1) begin n_long++; long_cyc = cyc; end
  endtask

  task automatic hold(input bit pin, input int n);
    for (int i = 0; i < n; i++) step(1'b0, pin);
  endtask

  initial begin
    int n0, p, r;
    bit val;

    // Reset held with the pin active, then the first press after reset.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("reset_mode", 32'(Mode), 32'd0);
    check("reset_level", 32'(Button_Level), 32'd0);
    n0 = cyc + 1;
    hold(1'b1, 8);
    check("press_latency", 32'(press_cyc), 32'(n0 + 6));
    check("press_level", 32'(Button_Level), 32'd1);
    n0 = cyc + 1;
    hold(1'b0, 8);
    check("release_latency", 32'(rel_cyc), 32'(n0 + 6));
    check("mode_after_click", 32'(Mode), 32'd1);

    // Press glitches: 4 cycles rejected, 5 cycles accepted.
    p = n_press;
    hold(1'b1, 4);
    hold(1'b0, 6);
    check("glitch4_press", 32'(n_press), 32'(p));
    check("glitch4_mode", 32'(Mode), 32'd1);
    hold(1'b1, 5);
    hold(1'b0, 8);
    check("glitch5_press", 32'(n_press), 32'(p + 1));
    check("glitch5_mode", 32'(Mode), 32'd2);

    // Long press from Mode=2.
    hold(1'b1, 25);
    check("long_count", 32'(n_long), 32'd1);
    check("long_delay", 32'(long_cyc - press_cyc), 32'd10);
    check("long_mode", 32'(Mode), 32'd0);
    r = n_rel;
    hold(1'b0, 8);
    check("long_release", 32'(n_rel), 32'(r + 1));
    check("long_release_mode", 32'(Mode), 32'd0);

    // Four short presses wrap Mode.
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
      check("wrap_mode", 32'(Mode), 32'((i + 1) % 4));
    end

    // Release bounce while pressed.
    hold(1'b1, 8);
    r = n_rel;
    hold(1'b0, 2);
    hold(1'b1, 6);
    check("bounce_release", 32'(n_rel), 32'(r));
    check("bounce_level", 32'(Button_Level), 32'd1);
    check("bounce_mode", 32'(Mode), 32'd0);
    hold(1'b0, 8);
    check("bounce_final_mode", 32'(Mode), 32'd1);

    // Reset while waiting out a press.
    p = n_press;
    hold(1'b1, 4);
    step(1'b1, 1'b1);
    hold(1'b0, 4);
    check("rst_pw_press", 32'(n_press), 32'(p));
    check("rst_pw_mode", 32'(Mode), 32'd0);
    n0 = cyc + 1;
    hold(1'b1, 8);
    check("rst_pw_idle", 32'(press_cyc), 32'(n0 + 6));
    hold(1'b0, 8);

    // Random run lengths with occasional resets.
    val = 1'b0;
    for (int s = 0; s < 60; s++) begin
      val = ~val;
      hold(val, $urandom_range(1, 14));
      if ($urandom_range(0, 19) == 0) step(1'b1, val);
    end
    hold(1'b0, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
